call_ret_seq: RTL and testbench

- Program-counter sequencer sitting directly upstream of the processor's return-address stack.
- Generates the PC and executes CALL, RET and JMP.
- Drives the stack's push, pop and data-in lines, and consumes its registered top-of-stack output.
- Tracks stack occupancy, enforces the stack's read-settle latency with a stall, and flags overflow and underflow.

---
 rtl/call_ret_seq.sv | 164 ++++++++++++++++
 tb/tb_call_ret_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/call_ret_seq.sv
// Program-counter sequencer feeding a return-address stack: CALL/RET/JMP, occupancy, settle stall, ovf/unf.
// Optional macro CALL_RET_SEQ_RA_FWD_EN forwards the last pushed return address so an unsettled RET need not stall.
module call_ret_seq #(
    parameter int               NBITS  = 8,
    parameter int               NADDR  = 7,
    parameter int               DEPTH  = 2,
    parameter logic [NBITS-1:0] RST_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             jmp,
    input  logic             call,
    input  logic             ret,
    input  logic [NBITS-1:0] target,
    input  logic [NBITS-1:0] stack_out,
    output logic [NBITS-1:0] pc,
    output logic             push,
    output logic             pop,
    output logic [NBITS-1:0] stack_in,
    output logic             stall,
    output logic [NADDR-1:0] depth,
    output logic             ovf,
    output logic             unf
);

    localparam logic [NADDR-1:0] DEPTH_C    = NADDR'(DEPTH);
    localparam logic [NBITS-1:0] ONE_C      = NBITS'(1);
    localparam logic [NADDR-1:0] DONE_C     = NADDR'(1);
    localparam logic [1:0]       SETTLED_C  = 2'd2;

    logic [NBITS-1:0] pc_q, pc_d;
    logic [NADDR-1:0] depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [1:0]       settle_q, settle_d;
    logic             push_s, pop_s, stall_s;
    logic             settled_s, nonempty_s, full_s, fwd_ok_s;
    logic [NBITS-1:0] pc_inc_s;
    logic [NBITS-1:0] ret_addr_s;

`ifdef CALL_RET_SEQ_RA_FWD_EN
    logic [NBITS-1:0] shadow_q, shadow_d;
    logic             shadow_vld_q, shadow_vld_d;
`endif

    assign pc_inc_s   = pc_q + ONE_C;
    assign settled_s  = (settle_q == SETTLED_C);
    assign nonempty_s = (depth_q != '0);
    assign full_s     = (depth_q == DEPTH_C);

`ifdef CALL_RET_SEQ_RA_FWD_EN
    // Shadow holds the top entry only while no pop has happened since the push.
    assign fwd_ok_s   = shadow_vld_q;
    assign ret_addr_s = settled_s ? stack_out : shadow_q;
`else
    assign fwd_ok_s   = 1'b0;
    assign ret_addr_s = stack_out;
`endif

    // Next-state and strobe decode with ret > call > jmp > increment priority.
    always_comb begin
        pc_d     = pc_q;
        depth_d  = depth_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        settle_d = settle_q;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        stall_s  = 1'b0;
        if (rst) begin
            pc_d     = RST_PC;
            depth_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            settle_d = SETTLED_C;
        end else begin
            // Stall reflects the settle counter even while en is low.
            if (ret && nonempty_s && !settled_s && !fwd_ok_s) begin
                stall_s = 1'b1;
            end else begin
                stall_s = 1'b0;
            end
            if (en) begin
                if (ret) begin
                    if (!nonempty_s) begin
                        unf_d = 1'b1;
                        pc_d  = pc_inc_s;
                    end else if (settled_s || fwd_ok_s) begin
                        pop_s   = 1'b1;
                        pc_d    = ret_addr_s;
                        depth_d = depth_q - DONE_C;
                    end else begin
                        pc_d = pc_q;
                    end
                end else if (call) begin
                    pc_d = target;
                    if (full_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_s  = 1'b1;
                        depth_d = depth_q + DONE_C;
                    end
                end else if (jmp) begin
                    pc_d = target;
                end else begin
                    pc_d = pc_inc_s;
                end
            end else begin
                pc_d = pc_q;
            end
            if (push_s || pop_s) begin
                settle_d = 2'd0;
            end else if (settled_s) begin
                settle_d = SETTLED_C;
            end else begin
                settle_d = settle_q + 2'd1;
            end
        end
    end

`ifdef CALL_RET_SEQ_RA_FWD_EN
    // Shadow return-address capture and validity tracking.
    always_comb begin
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        if (rst) begin
            shadow_vld_d = 1'b0;
        end else if (push_s) begin
            shadow_d     = pc_inc_s;
            shadow_vld_d = 1'b1;
        end else if (pop_s) begin
            shadow_vld_d = 1'b0;
        end else begin
            shadow_vld_d = shadow_vld_q;
        end
    end

    // Shadow register state.
    always_ff @(posedge clk) begin
        shadow_q     <= shadow_d;
        shadow_vld_q <= shadow_vld_d;
    end
`endif

    // Sequencer state registers; reset is folded into the _d logic.
    always_ff @(posedge clk) begin
        pc_q     <= pc_d;
        depth_q  <= depth_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
        settle_q <= settle_d;
    end

    assign pc       = pc_q;
    assign depth    = depth_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign push     = push_s;
    assign pop      = pop_s;
    assign stall    = stall_s;
    assign stack_in = pc_inc_s;

endmodule

// File: tb/tb_call_ret_seq.sv
// Scoreboard bench for call_ret_seq: a return-address queue model predicts each cycle, a monitor compares.
module tb_call_ret_seq;

    localparam int         NB    = 8;
    localparam int         NA    = 7;
    localparam int         DEP   = 2;
    localparam logic [7:0] RSTPC = 8'h10;

    logic          clk = 1'b0;
    logic          rst = 1'b0, en = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0;
    logic [NB-1:0] target = 8'h00, stack_out;
    logic [NB-1:0] pc, stack_in;
    logic          push, pop, stall, ovf, unf;
    logic [NA-1:0] depth;

    call_ret_seq #(.NBITS(NB), .NADDR(NA), .DEPTH(DEP), .RST_PC(RSTPC)) dut (
        .clk(clk), .rst(rst), .en(en), .jmp(jmp), .call(call), .ret(ret),
        .target(target), .stack_out(stack_out), .pc(pc), .push(push), .pop(pop),
        .stack_in(stack_in), .stall(stall), .depth(depth), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // Environment stack: registered pointer, then registered top-of-stack output.
    logic [7:0] mem [16];
    logic [3:0] sp;
    logic [7:0] top_d1;
    always @(posedge clk) begin
        if (rst) begin
            sp <= 4'd0;
        end else if (push) begin
            mem[sp] <= stack_in;
            sp      <= sp + 4'd1;
        end else if (pop) begin
            sp <= sp - 4'd1;
        end
        top_d1    <= (sp != 4'd0) ? mem[sp - 4'd1] : 8'hEE;
        stack_out <= top_d1;
    end

    typedef struct {
        logic       known;
        logic [7:0] pc;
        int         depth;
        logic       ovf, unf, push, pop, stall;
        logic [7:0] stack_in;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [7:0] m_pc = 8'h00;
    logic [7:0] rs[$];
    logic       m_ovf = 1'b0, m_unf = 1'b0, m_shv = 1'b0, m_known = 1'b0;
    int         since = 2;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    // Monitor: pops one expectation per cycle once inputs have settled.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("push", int'(push), int'(x.push));
                chk("pop", int'(pop), int'(x.pop));
                chk("stall", int'(stall), int'(x.stall));
                if (x.known) begin
                    chk("pc", int'(pc), int'(x.pc));
                    chk("depth", int'(depth), x.depth);
                    chk("ovf", int'(ovf), int'(x.ovf));
                    chk("unf", int'(unf), int'(x.unf));
                    chk("stack_in", int'(stack_in), int'(x.stack_in));
                end
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic j, input logic c,
                        input logic rt, input logic [7:0] tg);
        exp_t x;
        logic settled, fwd;
        @(negedge clk);
        rst = r; en = e; jmp = j; call = c; ret = rt; target = tg;
        x.known = m_known; x.pc = m_pc; x.depth = rs.size();
        x.ovf = m_ovf; x.unf = m_unf; x.stack_in = m_pc + 8'd1;
        x.push = 1'b0; x.pop = 1'b0; x.stall = 1'b0;
        settled = (since >= 2);
`ifdef CALL_RET_SEQ_RA_FWD_EN
        fwd = m_shv;
`else
        fwd = 1'b0;
`endif
        if (r) begin
            m_pc = RSTPC; rs.delete(); m_ovf = 1'b0; m_unf = 1'b0;
            since = 2; m_shv = 1'b0; m_known = 1'b1;
        end else begin
            x.stall = rt && (rs.size() > 0) && !settled && !fwd;
            if (e) begin
                if (rt) begin
                    if (rs.size() == 0) begin
                        m_unf = 1'b1; m_pc = m_pc + 8'd1;
                    end else if (settled || fwd) begin
                        x.pop = 1'b1; m_pc = rs.pop_back();
                    end
                end else if (c) begin
                    if (rs.size() < DEP) begin
                        x.push = 1'b1; rs.push_back(m_pc + 8'd1);
                    end else begin
                        m_ovf = 1'b1;
                    end
                    m_pc = tg;
                end else if (j) begin
                    m_pc = tg;
                end else begin
                    m_pc = m_pc + 8'd1;
                end
            end
            if (x.push) m_shv = 1'b1;
            if (x.pop) m_shv = 1'b0;
            since = (x.push || x.pop) ? 0 : ((since < 2) ? since + 1 : 2);
        end
        exp_q.push_back(x);
    endtask

    task automatic idle(); step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00); endtask
    task automatic do_jmp(input logic [7:0] t); step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, t); endtask
    task automatic do_call(input logic [7:0] t); step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, t); endtask
    task automatic do_ret(); step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55);
        idle(); idle(); idle();
        // call/return with settle gap
        do_jmp(8'h05); do_call(8'h40); idle(); idle(); do_ret(); idle();
        // ret right after call: stall then pop (or forwarded)
        do_jmp(8'h20); do_call(8'h30); do_ret(); do_ret(); do_ret(); idle();
        // overflow at DEPTH
        do_call(8'h50); idle(); idle(); do_call(8'h60); idle(); idle();
        do_call(8'h70); idle(); do_ret(); idle(); idle(); do_ret(); idle();
        // underflow
        do_jmp(8'h7F); do_ret(); idle();
        // priority: ret wins over call and jmp
        do_call(8'h90); idle(); idle(); step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA0); idle();
        // wrap
        do_jmp(8'hFF); idle(); idle();
        // en low holds state
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC0); step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC1); idle();
        // reset aborts a stalled ret
        do_call(8'h33); do_ret(); step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00); idle(); idle();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int  k;
            logic r, e, j, c, rt;
            k  = $urandom_range(0, 99);
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 9) != 0);
            rt = (k < 35);
            c  = (k >= 30 && k < 65);
            j  = (k >= 60 && k < 80);
            step(r, e, j, c, rt, 8'($urandom));
        end
        idle();
        repeat (2) @(negedge clk);
        #3;
        chk("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
